// File: rtl/ram_pkg.sv
// ram_pkg: shared types and default constants for the simple dual-port RAM.
//   clr_state_t      - clear-sequencer FSM state (CLEAR while zeroing, READY after)
//   DEF_*            - default parameter values used by ram_sdp and ram_clr_seq
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_ADDR_WIDTH   = 4;
    localparam int DEF_READ_LATENCY = 1;
    localparam int DEF_BYPASS       = 1;

endpackage

// File: rtl/ram_clr_seq.sv
// ram_clr_seq: clear sequencer for ram_sdp.
// After reset, or on clear_req while READY, it walks addresses 0..DEPTH-1,
// one per cycle, asking the array to write zero. It then returns to READY.
//   clk       - clock, rising edge
//   reset     - synchronous, active-high; restarts the clear from address 0
//   clear_req - one-cycle request to clear the array (ignored while clearing)
//   ready     - high only in READY
//   clr_we    - zero-write strobe for clr_addr
//   clr_addr  - address currently being zeroed
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_req,
    output logic                  ready,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    clr_state_t            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= CLEAR;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        ready      = 1'b0;
        clr_we     = 1'b0;
        case (state_reg)
            CLEAR: begin
                clr_we    = 1'b1;
                // Natural wrap brings the counter back to 0 after LAST_ADDR.
                addr_next = addr_reg + 1'b1;
                if (addr_reg == LAST_ADDR) begin
                    state_next = READY;
                end
            end
            READY: begin
                ready = 1'b1;
                if (clear_req) begin
                    state_next = CLEAR;
                    addr_next  = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                addr_next  = '0;
            end
        endcase
    end

    assign clr_addr = addr_reg;

endmodule

// File: rtl/ram_sdp.sv
// ram_sdp: simple dual-port RAM (one write port, one read port, one clock)
// with per-byte write mask, optional write-to-read bypass, 1 or 2 cycle read
// latency and a built-in sequenced clear.
//   clk, reset              - clock and synchronous active-high reset
//   clear_req               - request to zero the whole array (DEPTH cycles)
//   write_enb, wr_address,
//   data_in, byte_enb       - write port; byte_enb[i] enables data_in[8i+7:8i]
//   read_enb, rd_address    - read port
//   data_out, read_valid    - read result, READ_LATENCY cycles after read_enb
//   ready                   - array usable; both ports ignored while low
module ram_sdp
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int READ_LATENCY = DEF_READ_LATENCY,
    parameter int BYPASS       = DEF_BYPASS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear_req,
    input  logic                    write_enb,
    input  logic [ADDR_WIDTH-1:0]   wr_address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_enb,
    input  logic                    read_enb,
    input  logic [ADDR_WIDTH-1:0]   rd_address,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    read_valid,
    output logic                    ready
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    ram_clr_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr_seq (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .ready     (ready),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    // ---------------- write port: clear sequencer or user ----------------
    logic [NUM_BYTES-1:0]  wr_lane_en;
    logic [ADDR_WIDTH-1:0] wr_addr_mux;
    logic [DATA_WIDTH-1:0] wr_data_mux;

    always_comb begin
        wr_lane_en  = '0;
        wr_addr_mux = wr_address;
        wr_data_mux = data_in;
        if (clr_we) begin
            wr_lane_en  = '1;
            wr_addr_mux = clr_addr;
            wr_data_mux = '0;
        end else if (ready && write_enb) begin
            wr_lane_en = byte_enb;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (wr_lane_en[b]) begin
                mem[wr_addr_mux][b*8 +: 8] <= wr_data_mux[b*8 +: 8];
            end
        end
    end

    // ---------------- read port, stage 1 ----------------
    // The array read is read-before-write, so on a same-address collision
    // rd_word_reg holds the old word. For bypass we register the colliding
    // write's mask and data and merge them after the array register, which
    // keeps the array itself a plain registered-read memory.
    logic rd_fire;
    logic rd_hit;

    assign rd_fire = ready && read_enb;
    assign rd_hit  = rd_fire && write_enb && (wr_address == rd_address) && (BYPASS != 0);

    logic [DATA_WIDTH-1:0] rd_word_reg;
    logic                  hit_reg;
    logic [NUM_BYTES-1:0]  hit_be_reg;
    logic [DATA_WIDTH-1:0] hit_data_reg;
    logic                  rd_valid_s1_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_word_reg     <= '0;
            hit_reg         <= 1'b0;
            hit_be_reg      <= '0;
            hit_data_reg    <= '0;
            rd_valid_s1_reg <= 1'b0;
        end else begin
            rd_valid_s1_reg <= rd_fire;
            // Only a read updates these, so the result holds between reads.
            if (rd_fire) begin
                rd_word_reg  <= mem[rd_address];
                hit_reg      <= rd_hit;
                hit_be_reg   <= byte_enb;
                hit_data_reg <= data_in;
            end
        end
    end

    logic [DATA_WIDTH-1:0] merged_word;

    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_merge
        assign merged_word[gi*8 +: 8] = (hit_reg && hit_be_reg[gi]) ?
                                        hit_data_reg[gi*8 +: 8] :
                                        rd_word_reg[gi*8 +: 8];
    end

    // ---------------- optional second stage ----------------
    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] data_out_reg;
        logic                  rd_valid_s2_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                data_out_reg    <= '0;
                rd_valid_s2_reg <= 1'b0;
            end else begin
                rd_valid_s2_reg <= rd_valid_s1_reg;
                if (rd_valid_s1_reg) begin
                    data_out_reg <= merged_word;
                end
            end
        end

        assign data_out   = data_out_reg;
        assign read_valid = rd_valid_s2_reg;
    end else begin : g_lat1
        assign data_out   = merged_word;
        assign read_valid = rd_valid_s1_reg;
    end

endmodule
